// File: rtl/class5_pkg.sv
// Shared definitions for the class5 weight-enumeration path.
//  N     pattern width
//  CW    weight width
//  IDXW  beat-index width
//  state_t / IDLE, RUN, DONE   enumerator FSM encoding
//  first_pat(k), last_pat(k)   smallest/largest N-bit vector of popcount k
//  popcount(p)                 ones count of an N-bit vector
package class5_pkg;

    localparam int unsigned N    = 7;
    localparam int unsigned CW   = 3;
    localparam int unsigned IDXW = 6;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // (1<<k)-1, formed in N+1 bits so k == N does not overflow
    function automatic logic [N-1:0] first_pat(input logic [CW-1:0] k);
        logic [N:0] one;
        one = (N+1)'(1);
        return N'((one << k) - (N+1)'(1));
    endfunction

    // k ones packed against the MSB
    function automatic logic [N-1:0] last_pat(input logic [CW-1:0] k);
        logic [N-1:0] f;
        f = first_pat(k);
        return f << (N - 32'(k));
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] p);
        logic [CW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            c = c + CW'(p[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/class5_wenum_next.sv
// Combinational successor: next larger N-bit vector with the same popcount.
//  pat  in   N  current pattern (must not be the last pattern of its weight)
//  nxt  out  N  successor pattern
module class5_wenum_next
    import class5_pkg::*;
(
    input  logic [N-1:0] pat,
    output logic [N-1:0] nxt
);

    localparam int unsigned SW = $clog2(N + 3);

    logic [N:0]    p;
    logic [N:0]    c;
    logic [N:0]    r;
    logic [SW-1:0] tz;

    // Gosper's hack; division by the lowest set bit becomes a right shift by tz(c)
    always_comb begin
        p  = {1'b0, pat};
        c  = p & (~p + (N+1)'(1));
        r  = p + c;
        tz = '0;
        for (int unsigned i = 0; i <= N; i++) begin
            if (c[i]) tz = SW'(i);
        end
        nxt = N'(r | ((r ^ p) >> (tz + SW'(2))));
    end

endmodule

// File: rtl/class5_weight_enum.sv
// Enumerates every N-bit vector of popcount k in ascending order as a
// valid/ready stream with last/done marking.
//  clk, rst_n     clock, async active-low reset
//  start, weight  run request and k, sampled in IDLE
//  busy           high in RUN and DONE
//  out_valid/out_ready, out_pat, out_idx, out_last   output stream
//  done           1-cycle pulse after the final beat is accepted
//  err            1-cycle pulse on start with weight > N
//  chk_err        sticky popcount self-check flag (CLASS5_WENUM_CHECK_EN), else 0
module class5_weight_enum
    import class5_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [CW-1:0]   weight,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_pat,
    output logic [IDXW-1:0] out_idx,
    output logic            out_last,
    output logic            done,
    output logic            err,
    output logic            chk_err
);

    state_t          state_q, state_d;
    logic [CW-1:0]   k_q, k_d;
    logic [N-1:0]    pat_d, nxt_pat;
    logic [IDXW-1:0] idx_d;
    logic            last_d, valid_d, busy_d, done_d, err_d, chk_d;

    class5_wenum_next u_next (
        .pat (out_pat),
        .nxt (nxt_pat)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pat_d   = out_pat;
        idx_d   = out_idx;
        last_d  = out_last;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // widened so the range check stays meaningful for any N/CW pairing
                    if (32'(weight) <= N) begin
                        state_d = RUN;
                        k_d     = weight;
                        pat_d   = first_pat(weight);
                        idx_d   = '0;
                        last_d  = (first_pat(weight) == last_pat(weight));
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        state_d = DONE;
                    end else begin
                        pat_d  = nxt_pat;
                        idx_d  = out_idx + IDXW'(1);
                        last_d = (nxt_pat == last_pat(k_q));
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == RUN);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

`ifdef CLASS5_WENUM_CHECK_EN
    // Sticky popcount check on every valid beat, cleared by a new start
    always_comb begin
        chk_d = chk_err;
        if (state_q == IDLE && start) begin
            chk_d = 1'b0;
        end else if (out_valid && (popcount(out_pat) != k_q)) begin
            chk_d = 1'b1;
        end
    end
`else
    assign chk_d = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            out_pat   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            chk_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            out_pat   <= pat_d;
            out_idx   <= idx_d;
            out_last  <= last_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            chk_err   <= chk_d;
        end
    end

endmodule
